// File: rtl/bp_update_scheduler.sv
// Serialises resolved-branch outcomes from two execute pipes into the predictor's
// single update port, with round-robin arbitration, an in-order FIFO and a timed flush.
module bp_update_scheduler #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0_valid,
    input  logic                         req0_taken,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic                         req1_taken,
    output logic                         req1_ready,
    input  logic                         hold,
    input  logic                         flush,
    output logic                         pred_update,
    output logic                         pred_taken,
    output logic                         pred_reset,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   occ;
    logic            rr;
    logic [FW-1:0]   fcnt;
    logic            reset_q;

    logic active;
    logic accept;
    logic grant0;
    logic grant1;
    logic push;
    logic push_taken;
    logic pop;

    // Outputs are blanked during reset and for the first cycle after it drops.
    always_comb begin
        active     = !reset && !reset_q;
        accept     = active && (state == RUN) && !flush && (occ < CW'(DEPTH));
        grant0     = accept && req0_valid && (!req1_valid || !rr);
        grant1     = accept && req1_valid && (!req0_valid || rr);
        push       = grant0 || grant1;
        push_taken = grant0 ? req0_taken : req1_taken;
        pop        = active && (state == RUN) && (occ != '0) && !hold;
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign pred_update = pop;
    assign pred_taken  = active && mem[head];
    assign pred_reset  = active && (state == FLUSH);
    assign count       = active ? occ : '0;
    assign busy        = active && ((occ != '0) || (state == FLUSH));

    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            rr    <= 1'b0;
            fcnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= FLUSH;
                        head  <= '0;
                        tail  <= '0;
                        occ   <= '0;
                        fcnt  <= FW'(FLUSH_CYCLES - 1);
                    end else begin
                        if (push) begin
                            mem[tail] <= push_taken;
                            tail      <= tail + AW'(1);
                        end
                        if (pop) begin
                            head <= head + AW'(1);
                        end
                        case ({push, pop})
                            2'b10:   occ <= occ + CW'(1);
                            2'b01:   occ <= occ - CW'(1);
                            default: occ <= occ;
                        endcase
                        // Pointer only moves when both pipes competed for the slot.
                        if (push && req0_valid && req1_valid) begin
                            rr <= ~rr;
                        end
                    end
                end
                FLUSH: begin
                    if (flush) begin
                        fcnt <= FW'(FLUSH_CYCLES - 1);
                    end else if (fcnt == '0) begin
                        state <= RUN;
                    end else begin
                        fcnt <= fcnt - FW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
